// File: rtl/seq_divider.sv
// seq_divider: multicycle signed restoring divider for the HI/LO registers.
// lo = quotient (truncated toward zero), hi = remainder (sign of dividend).
// One restoring step per clock, WIDTH steps, then a sign-fix cycle.
// Optional build macro SEQ_DIVIDER_UNSIGNED_EN adds the div_unsigned port (DIVU).
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             div_start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIVIDER_UNSIGNED_EN
   input  logic             div_unsigned,
`endif
   output logic             div_end,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_t;

   state_t state, state_n;

   logic             start_q;
   logic             start_ev;
   logic             uns;
   logic             load;
   logic             zero_hit;
   logic             step;
   logic             fix;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs;
   logic             sign_q;
   logic             sign_r;
   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dvs_mag;
   logic [WIDTH:0]   rem_sh;
   logic             trial_ok;

`ifdef SEQ_DIVIDER_UNSIGNED_EN
   assign uns = div_unsigned;
`else
   assign uns = 1'b0;
`endif

   assign start_ev = div_start & ~start_q;

   // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
   assign dvd_mag = (!uns && dividend[WIDTH-1]) ? -dividend : dividend;
   assign dvs_mag = (!uns && divisor[WIDTH-1])  ? -divisor  : divisor;

   // Shifted partial remainder needs one extra bit so unsigned divisors near
   // 2^WIDTH still compare correctly; the subtraction result always fits WIDTH.
   assign rem_sh   = {rem, quo[WIDTH-1]};
   assign trial_ok = (rem_sh >= {1'b0, dvs});

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Start edge detector register.
   always_ff @(posedge clk) begin
      if (rst) start_q <= 1'b0;
      else     start_q <= div_start;
   end

   // Next-state logic and datapath control strobes.
   always_comb begin
      state_n  = state;
      load     = 1'b0;
      zero_hit = 1'b0;
      step     = 1'b0;
      fix      = 1'b0;
      case (state)
         IDLE: begin
            if (start_ev) begin
               if (divisor == '0) begin
                  zero_hit = 1'b1;
               end else begin
                  load    = 1'b1;
                  state_n = CALC;
               end
            end
         end
         CALC: begin
            step = 1'b1;
            if (count == CW'(WIDTH - 1)) state_n = FIX;
         end
         FIX: begin
            fix     = 1'b1;
            state_n = DONE;
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Datapath: operand latch, restoring steps, sign fix and result flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         rem         <= '0;
         quo         <= '0;
         dvs         <= '0;
         count       <= '0;
         sign_q      <= 1'b0;
         sign_r      <= 1'b0;
         hi          <= '0;
         lo          <= '0;
         div_end     <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         div_end     <= fix;
         div_by_zero <= zero_hit;
         if (load) begin
            dvs    <= dvs_mag;
            quo    <= dvd_mag;
            rem    <= '0;
            count  <= '0;
            sign_q <= ~uns & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            sign_r <= ~uns & dividend[WIDTH-1];
         end else if (step) begin
            rem   <= trial_ok ? (rem_sh[WIDTH-1:0] - dvs) : rem_sh[WIDTH-1:0];
            quo   <= {quo[WIDTH-2:0], trial_ok};
            count <= count + CW'(1);
         end
         if (fix) begin
            lo <= sign_q ? -quo : quo;
            hi <= sign_r ? -rem : rem;
         end
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard-driven self-checking bench for seq_divider.
module tb_seq_divider;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         div_start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
`ifdef SEQ_DIVIDER_UNSIGNED_EN
   logic         div_unsigned;
`endif
   logic         div_end;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic         div_by_zero;

   int vectors = 0;
   int errors  = 0;

   typedef struct {
      logic [W-1:0] lo;
      logic [W-1:0] hi;
   } exp_t;

   exp_t sb[$];

   seq_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .div_start   (div_start),
      .dividend    (dividend),
      .divisor     (divisor),
`ifdef SEQ_DIVIDER_UNSIGNED_EN
      .div_unsigned(div_unsigned),
`endif
      .div_end     (div_end),
      .hi          (hi),
      .lo          (lo),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got running required stopped");
      $fatal(1, "watchdog");
   end

   task automatic push_exp(input logic [W-1:0] l, input logic [W-1:0] h);
      exp_t e;
      e.lo = l;
      e.hi = h;
      sb.push_back(e);
   endtask

   // Drive one start pulse, then wait (bounded) for div_end or div_by_zero.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic u,
                        output logic got_end, output logic got_dbz, output logic both,
                        output int cyc, output logic [W-1:0] h, output logic [W-1:0] l,
                        output logic after);
      @(negedge clk);
      dividend  = a;
      divisor   = b;
`ifdef SEQ_DIVIDER_UNSIGNED_EN
      div_unsigned = u;
`else
      if (u) $display("note: unsigned request ignored in signed-only build");
`endif
      div_start = 1'b1;
      @(posedge clk);
      #1 div_start = 1'b0;
      got_end = 1'b0;
      got_dbz = 1'b0;
      both    = 1'b0;
      cyc     = 0;
      h       = '0;
      l       = '0;
      for (int i = 0; i < 60 && !got_end && !got_dbz; i++) begin
         @(negedge clk);
         cyc++;
         if (div_end && div_by_zero) both = 1'b1;
         got_end = div_end;
         got_dbz = div_by_zero;
         h = hi;
         l = lo;
      end
      @(negedge clk);
      after = div_end | div_by_zero;
   endtask

   task automatic test_reset;
      rst       = 1'b1;
      div_start = 1'b0;
      dividend  = '0;
      divisor   = '0;
`ifdef SEQ_DIVIDER_UNSIGNED_EN
      div_unsigned = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if ({hi, lo} !== '0) begin
         errors++;
         $display("FAIL reset_hilo: got hi=%h lo=%h required 0/0", hi, lo);
      end
      vectors++;
      if ({div_end, div_by_zero} !== 2'b00) begin
         errors++;
         $display("FAIL reset_flags: got end=%b dbz=%b required 0/0", div_end, div_by_zero);
      end
   endtask

   task automatic test_signed;
      logic [W-1:0] tbl [7][4];
      logic ge, gz, bo, af;
      int cyc;
      logic [W-1:0] h, l;
      exp_t e;
      // {dividend, divisor, lo, hi}
      tbl[0] = '{32'd7,         32'd2,          32'h00000003, 32'h00000001};
      tbl[1] = '{32'hFFFFFFF9,  32'd2,          32'hFFFFFFFD, 32'hFFFFFFFF};
      tbl[2] = '{32'd7,         32'hFFFFFFFE,   32'hFFFFFFFD, 32'h00000001};
      tbl[3] = '{32'hFFFFFFF9,  32'hFFFFFFFE,   32'h00000003, 32'hFFFFFFFF};
      tbl[4] = '{32'd5,         32'd7,          32'h00000000, 32'h00000005};
      tbl[5] = '{32'h80000000,  32'hFFFFFFFF,   32'h80000000, 32'h00000000};
      tbl[6] = '{32'h80000000,  32'd7,          32'hEDB6DB6E, 32'hFFFFFFFE};
      for (int i = 0; i < 7; i++) begin
         push_exp(tbl[i][2], tbl[i][3]);
         do_op(tbl[i][0], tbl[i][1], 1'b0, ge, gz, bo, cyc, h, l, af);
         e = sb.pop_front();
         vectors++;
         if (!ge || gz || bo || cyc != 34) begin
            errors++;
            $display("FAIL signed_latency[%0d]: got end=%b dbz=%b both=%b cyc=%0d required end=1 dbz=0 cyc=34",
                     i, ge, gz, bo, cyc);
         end
         vectors++;
         if (l !== e.lo || h !== e.hi) begin
            errors++;
            $display("FAIL signed_result[%0d]: got lo=%h hi=%h required lo=%h hi=%h", i, l, h, e.lo, e.hi);
         end
         vectors++;
         if (af !== 1'b0) begin
            errors++;
            $display("FAIL signed_pulse[%0d]: got end/dbz next cycle=%b required 0", i, af);
         end
      end
   endtask

   task automatic test_div_zero;
      logic ge, gz, bo, af;
      int cyc, late;
      logic [W-1:0] h, l;
      exp_t e;
      push_exp(32'd3, 32'd1);
      do_op(32'd7, 32'd2, 1'b0, ge, gz, bo, cyc, h, l, af);
      e = sb.pop_front();
      vectors++;
      if (!ge || l !== e.lo || h !== e.hi) begin
         errors++;
         $display("FAIL dbz_setup: got end=%b lo=%h hi=%h required end=1 lo=%h hi=%h", ge, l, h, e.lo, e.hi);
      end
      // hi/lo must hold the previous result when the divisor is zero
      push_exp(32'd3, 32'd1);
      do_op(32'd5, 32'd0, 1'b0, ge, gz, bo, cyc, h, l, af);
      e = sb.pop_front();
      vectors++;
      if (!gz || ge || bo || cyc != 1) begin
         errors++;
         $display("FAIL dbz_flag: got dbz=%b end=%b both=%b cyc=%0d required dbz=1 end=0 cyc=1", gz, ge, bo, cyc);
      end
      vectors++;
      if (l !== e.lo || h !== e.hi) begin
         errors++;
         $display("FAIL dbz_hold: got lo=%h hi=%h required lo=%h hi=%h", l, h, e.lo, e.hi);
      end
      vectors++;
      if (af !== 1'b0) begin
         errors++;
         $display("FAIL dbz_pulse: got flag next cycle=%b required 0", af);
      end
      late = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (div_end || div_by_zero) late++;
      end
      vectors++;
      if (late != 0 || lo !== e.lo || hi !== e.hi) begin
         errors++;
         $display("FAIL dbz_quiet: got %0d late pulses lo=%h hi=%h required 0 pulses lo=%h hi=%h",
                  late, lo, hi, e.lo, e.hi);
      end
      push_exp(32'd3, 32'd0);
      do_op(32'd9, 32'd3, 1'b0, ge, gz, bo, cyc, h, l, af);
      e = sb.pop_front();
      vectors++;
      if (!ge || cyc != 34 || l !== e.lo || h !== e.hi) begin
         errors++;
         $display("FAIL dbz_next: got end=%b cyc=%0d lo=%h hi=%h required end=1 cyc=34 lo=%h hi=%h",
                  ge, cyc, l, h, e.lo, e.hi);
      end
   endtask

`ifdef SEQ_DIVIDER_UNSIGNED_EN
   task automatic test_unsigned;
      logic ge, gz, bo, af;
      int cyc;
      logic [W-1:0] h, l;
      exp_t e;
      push_exp(32'h7FFFFFFF, 32'd1);
      do_op(32'hFFFFFFFF, 32'd2, 1'b1, ge, gz, bo, cyc, h, l, af);
      e = sb.pop_front();
      vectors++;
      if (!ge || cyc != 34 || l !== e.lo || h !== e.hi) begin
         errors++;
         $display("FAIL divu: got end=%b cyc=%0d lo=%h hi=%h required end=1 cyc=34 lo=%h hi=%h",
                  ge, cyc, l, h, e.lo, e.hi);
      end
      push_exp(32'd1, 32'h7FFFFFFF);
      do_op(32'hFFFFFFFF, 32'h80000000, 1'b1, ge, gz, bo, cyc, h, l, af);
      e = sb.pop_front();
      vectors++;
      if (!ge || l !== e.lo || h !== e.hi) begin
         errors++;
         $display("FAIL divu_big: got end=%b lo=%h hi=%h required end=1 lo=%h hi=%h", ge, l, h, e.lo, e.hi);
      end
   endtask
`endif

   task automatic test_random;
      logic ge, gz, bo, af;
      int cyc;
      logic [W-1:0] h, l, a, b;
      int signed sa, sd;
      exp_t e;
      for (int i = 0; i < 8; i++) begin
         a  = $urandom;
         b  = $urandom;
         sd = $signed(b) >>> $urandom_range(0, 28);
         if (sd == 0) sd = 5;
         if (a == 32'h80000000 && sd == -1) sd = 3;
         sa = $signed(a);
         push_exp(sa / sd, sa % sd);
         do_op(a, sd, 1'b0, ge, gz, bo, cyc, h, l, af);
         e = sb.pop_front();
         vectors++;
         if (!ge || cyc != 34 || l !== e.lo || h !== e.hi) begin
            errors++;
            $display("FAIL random[%0d] %h/%h: got end=%b cyc=%0d lo=%h hi=%h required end=1 cyc=34 lo=%h hi=%h",
                     i, a, sd, ge, cyc, l, h, e.lo, e.hi);
         end
      end
   endtask

   task automatic test_hold_start;
      int pulses, dbz_seen;
      logic [W-1:0] h, l;
      exp_t e;
      pulses   = 0;
      dbz_seen = 0;
      h        = '0;
      l        = '0;
      @(negedge clk);
      dividend  = 32'd100;
      divisor   = 32'd7;
`ifdef SEQ_DIVIDER_UNSIGNED_EN
      div_unsigned = 1'b0;
`endif
      div_start = 1'b1;
      push_exp(32'd14, 32'd2);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (i == 5) begin
            dividend = 32'd1;
            divisor  = 32'd1;
         end
         if (div_by_zero) dbz_seen++;
         if (div_end) begin
            pulses++;
            h = hi;
            l = lo;
         end
      end
      div_start = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (div_end) pulses++;
      end
      e = sb.pop_front();
      vectors++;
      if (pulses != 1 || dbz_seen != 0) begin
         errors++;
         $display("FAIL hold_pulses: got %0d end pulses %0d dbz required 1 and 0", pulses, dbz_seen);
      end
      vectors++;
      if (l !== e.lo || h !== e.hi) begin
         errors++;
         $display("FAIL hold_result: got lo=%h hi=%h required lo=%h hi=%h", l, h, e.lo, e.hi);
      end
   endtask

   task automatic test_reset_mid;
      logic ge, gz, bo, af;
      int cyc;
      logic [W-1:0] h, l;
      exp_t e;
      @(negedge clk);
      dividend  = 32'd1000;
      divisor   = 32'd3;
      div_start = 1'b1;
      @(posedge clk);            // E0
      #1 div_start = 1'b0;
      repeat (9) @(posedge clk); // E1..E9
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);            // E10
      @(negedge clk);
      vectors++;
      if ({hi, lo, div_end, div_by_zero} !== '0) begin
         errors++;
         $display("FAIL reset_mid: got hi=%h lo=%h end=%b dbz=%b required all 0", hi, lo, div_end, div_by_zero);
      end
      rst = 1'b0;
      push_exp(32'd333, 32'd1);
      do_op(32'd1000, 32'd3, 1'b0, ge, gz, bo, cyc, h, l, af);
      e = sb.pop_front();
      vectors++;
      if (!ge || gz || cyc != 34 || l !== e.lo || h !== e.hi) begin
         errors++;
         $display("FAIL reset_restart: got end=%b dbz=%b cyc=%0d lo=%h hi=%h required end=1 dbz=0 cyc=34 lo=%h hi=%h",
                  ge, gz, cyc, l, h, e.lo, e.hi);
      end
   endtask

   initial begin
      test_reset;
      test_signed;
      test_div_zero;
`ifdef SEQ_DIVIDER_UNSIGNED_EN
      test_unsigned;
`endif
      test_random;
      test_hold_start;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
